mac_ve5_1_requant: RTL and testbench

- Output-side companion of the ve5_1 MAC. It consumes finished accumulator results: 28-bit int accumulator in int8 mode, or 18-bit {exp5, signed man13} accumulator in fp mode.
- It requantizes each result into the 16-bit activation word the MAC takes on its value input, ready for write-back to activation memory.
- Implemented as a 2-stage valid/ready pipeline with a sticky clamp counter for calibration.

---
 rtl/mac_ve5_1_requant.sv | 151 +++++++++++++++
 tb/tb_mac_ve5_1_requant.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_ve5_1_requant.sv
`default_nettype none
// ============================================================================
// Module : mac_ve5_1_requant
// Brief  : Two-stage valid/ready requantizer turning ve5_1 MAC accumulator
//          results (int28 or {exp5, man13}) into 16-bit activation words.
// Rev    : 1.0  initial release
// ============================================================================
module mac_ve5_1_requant #(
  parameter int INT_RELU = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [27:0]      in_int,
  input  logic [17:0]      in_fp,
  input  logic [4:0]       in_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_clamp,
  input  logic             clr,
  output logic [CNT_W-1:0] clamp_cnt
);

  localparam logic signed [28:0] c_sat_hi = 29'sd127;
  localparam logic signed [28:0] c_sat_lo = (INT_RELU != 0) ? 29'sd0 : -29'sd128;

  logic                    w_s2_adv;
  logic                    w_s1_adv;
  logic                    w_accept;
  logic [32:0]             w_rnd;
  logic signed [32:0]      w_sum;
  logic signed [28:0]      w_int_r;
  logic [3:0]              w_k;
  logic [10:0]             w_norm;
  logic [15:0]             w_q_data;
  logic                    w_q_clamp;

  logic                    r_s1_valid;
  logic                    r_s1_mode;
  logic signed [28:0]      r_s1_int;
  logic [4:0]              r_s1_exp;
  logic [11:0]             r_s1_man;
  logic [3:0]              r_s1_k;
  logic                    r_s1_neg;
  logic                    r_s1_zero;
  logic                    r_out_valid;
  logic [15:0]             r_out_data;
  logic                    r_out_clamp;
  logic [CNT_W-1:0]        r_clamp_cnt;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_accept = in_valid && w_s1_adv;

  // Sum is kept at 33 bits so the rounding term for shifts up to 31 stays exact.
  always_comb begin
    w_rnd   = (in_shift != 5'd0) ? (33'd1 << (in_shift - 5'd1)) : 33'd0;
    w_sum   = $signed({{5{in_int[27]}}, in_int}) + $signed(w_rnd);
    w_int_r = 29'(w_sum >>> in_shift);
    w_k     = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (in_fp[i]) w_k = 4'(11 - i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_int   <= '0;
      r_s1_exp   <= '0;
      r_s1_man   <= '0;
      r_s1_k     <= '0;
      r_s1_neg   <= 1'b0;
      r_s1_zero  <= 1'b0;
    end else begin
      if (w_s1_adv) r_s1_valid <= in_valid;
      if (w_accept) begin
        r_s1_mode <= in_mode;
        r_s1_int  <= w_int_r;
        r_s1_exp  <= in_fp[17:13];
        r_s1_man  <= in_fp[11:0];
        r_s1_k    <= w_k;
        r_s1_neg  <= in_fp[12];
        r_s1_zero <= (in_fp[12:0] == 13'd0);
      end
    end
  end

  // Bit 11 of the normalized mantissa is the hidden one and is dropped.
  always_comb begin
    w_norm    = 11'(r_s1_man << r_s1_k);
    w_q_data  = 16'h0000;
    w_q_clamp = 1'b0;
    if (!r_s1_mode) begin
      if (r_s1_int > c_sat_hi) begin
        w_q_data  = 16'h007F;
        w_q_clamp = 1'b1;
      end else if (r_s1_int < c_sat_lo) begin
        w_q_data  = 16'(c_sat_lo);
        w_q_clamp = 1'b1;
      end else begin
        w_q_data  = 16'(r_s1_int);
      end
    end else if (r_s1_neg) begin
      w_q_clamp = 1'b1;
    end else if (r_s1_zero) begin
      w_q_clamp = 1'b0;
    end else if (r_s1_exp < {1'b0, r_s1_k}) begin
      w_q_clamp = 1'b1;
    end else begin
      w_q_data  = {r_s1_exp - {1'b0, r_s1_k}, w_norm};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_clamp <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data  <= w_q_data;
        r_out_clamp <= w_q_clamp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clamp_cnt <= '0;
    end else if (clr) begin
      r_clamp_cnt <= '0;
    end else if (r_out_valid && out_ready && r_out_clamp && (r_clamp_cnt != '1)) begin
      r_clamp_cnt <= r_clamp_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready  = w_s1_adv;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_clamp = r_out_clamp;
  assign clamp_cnt = r_clamp_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mac_ve5_1_requant.sv
`default_nettype none
// ============================================================================
// Module : tb_mac_ve5_1_requant
// Brief  : Self-checking bench for mac_ve5_1_requant (signed and ReLU builds).
// Rev    : 1.0  initial release
// ============================================================================
module tb_mac_ve5_1_requant;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_mode, out_ready, clr;
  logic [27:0] in_int;
  logic [17:0] in_fp;
  logic [4:0]  in_shift;
  logic        in_ready, out_valid, out_clamp;
  logic [15:0] out_data, clamp_cnt;
  logic        in_ready_r, out_valid_r, out_clamp_r;
  logic [15:0] out_data_r, clamp_cnt_r;

  always #5 clk = ~clk;

  mac_ve5_1_requant #(.INT_RELU(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_int(in_int), .in_fp(in_fp), .in_shift(in_shift), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_clamp(out_clamp), .clr(clr),
    .clamp_cnt(clamp_cnt));

  mac_ve5_1_requant #(.INT_RELU(1), .CNT_W(16)) dut_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .in_mode(in_mode),
    .in_int(in_int), .in_fp(in_fp), .in_shift(in_shift), .out_valid(out_valid_r),
    .out_ready(out_ready), .out_data(out_data_r), .out_clamp(out_clamp_r), .clr(clr),
    .clamp_cnt(clamp_cnt_r));

  int n_vec = 0;
  int n_fail = 0;
  logic [16:0] exp_q[$], obs_q[$], expr_q[$], obsr_q[$];
  int n_out = 0, n_out_r = 0;
  int cnt_m = 0, cnt_mr = 0;
  bit last_in_hs = 1'b0;

  // Reference: round-half-up shift of the real value, then clip to the int8 range.
  function automatic logic [16:0] ref_int(int v, int sh, bit relu);
    longint x, lo, sat;
    x = v;
    if (sh > 0) x = x + (longint'(1) << (sh - 1));
    x = x >>> sh;
    lo = relu ? 0 : -128;
    sat = (x > 127) ? 127 : ((x < lo) ? lo : x);
    return {16'(sat), (sat != x)};
  endfunction

  // Reference: normalize by doubling until the hidden bit is set, one exponent step each.
  function automatic logic [16:0] ref_fp(logic [17:0] f);
    int e, m;
    if (f[12]) return {16'h0000, 1'b1};
    m = int'(f[11:0]);
    if (m == 0) return 17'h0;
    e = int'(f[17:13]);
    while (m < 2048) begin
      m = m * 2;
      e = e - 1;
    end
    if (e < 0) return {16'h0000, 1'b1};
    return {5'(e), 11'(m), 1'b0};
  endfunction

  always @(negedge clk) begin
    bit inc, inc_r;
    if (rst) begin
      cnt_m = 0; cnt_mr = 0; last_in_hs = 1'b0;
    end else begin
      last_in_hs = in_valid && in_ready;
      if (last_in_hs) begin
        exp_q.push_back(in_mode ? ref_fp(in_fp) : ref_int(int'($signed(in_int)), int'(in_shift), 1'b0));
        expr_q.push_back(in_mode ? ref_fp(in_fp) : ref_int(int'($signed(in_int)), int'(in_shift), 1'b1));
      end
      inc = 1'b0; inc_r = 1'b0;
      if (out_valid && out_ready) begin
        obs_q.push_back({out_data, out_clamp});
        inc = (n_out < exp_q.size()) ? exp_q[n_out][0] : 1'b0;
        n_out++;
      end
      if (out_valid_r && out_ready) begin
        obsr_q.push_back({out_data_r, out_clamp_r});
        inc_r = (n_out_r < expr_q.size()) ? expr_q[n_out_r][0] : 1'b0;
        n_out_r++;
      end
      if (clr) cnt_m = 0; else if (inc && cnt_m < 65535) cnt_m++;
      if (clr) cnt_mr = 0; else if (inc_r && cnt_mr < 65535) cnt_mr++;
    end
  end

  task automatic clear_q;
    exp_q.delete(); obs_q.delete(); expr_q.delete(); obsr_q.delete();
    n_out = 0; n_out_r = 0;
  endtask

  task automatic drain(output bit ok);
    in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!out_valid && obs_q.size() == exp_q.size() && obsr_q.size() == expr_q.size()) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_int = '0; in_fp = '0; in_shift = '0;
    out_ready = 1'b1; clr = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0000", out_data); end
    n_vec++; if (out_clamp !== 1'b0) begin n_fail++; $display("FAIL reset_clamp: got %b want 0", out_clamp); end
    n_vec++; if (clamp_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0000", clamp_cnt); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    clear_q();
  endtask

  typedef struct {
    bit mode; int iv; int sh; logic [17:0] fp;
    logic [15:0] d; bit c; logic [15:0] dr; bit cr;
  } dvec_t;

  task automatic test_directed;
    dvec_t tbl[14];
    int nc = 0, ncr = 0;
    tbl = '{
      '{1'b0, 1000, 3, 18'h0, 16'h007D, 1'b0, 16'h007D, 1'b0},
      '{1'b0, -1000, 2, 18'h0, 16'hFF80, 1'b1, 16'h0000, 1'b1},
      '{1'b1, 0, 0, {5'd15, 13'h0C00}, 16'h7C00, 1'b0, 16'h7C00, 1'b0},
      '{1'b1, 0, 0, {5'd15, 13'h0300}, 16'h6C00, 1'b0, 16'h6C00, 1'b0},
      '{1'b1, 0, 0, {5'd1, 13'h0100}, 16'h0000, 1'b1, 16'h0000, 1'b1},
      '{1'b1, 0, 0, {5'd20, 13'h1C00}, 16'h0000, 1'b1, 16'h0000, 1'b1},
      '{1'b1, 0, 0, {5'd20, 13'h0000}, 16'h0000, 1'b0, 16'h0000, 1'b0},
      '{1'b0, -3, 1, 18'h0, 16'hFFFF, 1'b0, 16'h0000, 1'b1},
      '{1'b0, 128, 0, 18'h0, 16'h007F, 1'b1, 16'h007F, 1'b1},
      '{1'b0, -128, 0, 18'h0, 16'hFF80, 1'b0, 16'h0000, 1'b1},
      '{1'b0, 127, 0, 18'h0, 16'h007F, 1'b0, 16'h007F, 1'b0},
      '{1'b0, 1020, 3, 18'h0, 16'h007F, 1'b1, 16'h007F, 1'b1},
      '{1'b1, 0, 0, {5'd0, 13'h0800}, 16'h0000, 1'b0, 16'h0000, 1'b0},
      '{1'b0, -5, 31, 18'h0, 16'h0000, 1'b0, 16'h0000, 1'b0}
    };
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; in_mode = tbl[i].mode; in_int = 28'(tbl[i].iv);
      in_shift = 5'(tbl[i].sh); in_fp = tbl[i].fp;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early_valid: got %b want 0", i, out_valid); end
      @(posedge clk); #1;
      n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_valid: got %b want 1", i, out_valid); end
      n_vec++; if (out_data !== tbl[i].d) begin n_fail++; $display("FAIL dir%0d_data: got %h want %h", i, out_data, tbl[i].d); end
      n_vec++; if (out_clamp !== tbl[i].c) begin n_fail++; $display("FAIL dir%0d_clamp: got %b want %b", i, out_clamp, tbl[i].c); end
      n_vec++; if (out_data_r !== tbl[i].dr) begin n_fail++; $display("FAIL dir%0d_relu_data: got %h want %h", i, out_data_r, tbl[i].dr); end
      n_vec++; if (out_clamp_r !== tbl[i].cr) begin n_fail++; $display("FAIL dir%0d_relu_clamp: got %b want %b", i, out_clamp_r, tbl[i].cr); end
      if (tbl[i].c) nc++;
      if (tbl[i].cr) ncr++;
      @(posedge clk); #1;
    end
    n_vec++; if (clamp_cnt !== 16'(nc)) begin n_fail++; $display("FAIL dir_cnt: got %0d want %0d", clamp_cnt, nc); end
    n_vec++; if (clamp_cnt_r !== 16'(ncr)) begin n_fail++; $display("FAIL dir_relu_cnt: got %0d want %0d", clamp_cnt_r, ncr); end
    clear_q();
  endtask

  task automatic test_back_to_back;
    int words[4];
    int sent = 0;
    logic [16:0] w0;
    bit ok;
    for (int i = 0; i < 4; i++) words[i] = int'($urandom_range(0, 8000)) - 4000;
    w0 = ref_int(words[0], 4, 1'b0);
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (last_in_hs) sent++;
      out_ready = !(c >= 2 && c <= 5);
      in_valid = (sent < 4); in_mode = 1'b0; in_shift = 5'd4;
      if (sent < 4) in_int = 28'(words[sent]);
      #1;
      if (c >= 2 && c <= 5) begin
        n_vec++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready_c%0d: got %b want 0", c, in_ready); end
        n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_c%0d: got %b want 1", c, out_valid); end
      end
      if (c >= 2 && c <= 6) begin
        n_vec++; if (out_data !== w0[16:1]) begin n_fail++; $display("FAIL b2b_hold_c%0d: got %h want %h", c, out_data, w0[16:1]); end
      end
    end
    drain(ok);
    n_vec++; if (!ok) begin n_fail++; $display("FAIL b2b_drain: got timeout want drained"); end
    n_vec++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    clear_q();
  endtask

  task automatic test_random;
    int accepted = 0;
    int budget;
    int v, sh, cls;
    logic [17:0] f;
    bit ok;
    in_valid = 1'b0;
    for (budget = 0; budget < 5000 && (accepted < 200 || in_valid); budget++) begin
      @(posedge clk); #1;
      if (last_in_hs) accepted++;
      if (!in_valid || last_in_hs) begin
        in_valid = (accepted < 200) && ($urandom_range(0, 3) != 0);
        in_mode = 1'($urandom_range(0, 1));
        cls = $urandom_range(0, 2);
        if (cls == 0) begin
          sh = $urandom_range(0, 3); v = int'($urandom_range(0, 600)) - 300;
        end else if (cls == 1) begin
          sh = $urandom_range(0, 31); v = int'($signed(28'($urandom)));
        end else begin
          sh = $urandom_range(0, 6);
          v = int'($urandom_range(120, 135)) * (1 << sh) + int'($urandom_range(0, 63)) % (1 << sh);
          if ($urandom_range(0, 1) == 1) v = -v;
        end
        in_int = 28'(v); in_shift = 5'(sh);
        f = 18'($urandom);
        if ($urandom_range(0, 1) == 1) f[12] = 1'b0;
        if ($urandom_range(0, 7) == 0) f[12:0] = 13'h0;
        in_fp = f;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
    end
    n_vec++; if (accepted < 200) begin n_fail++; $display("FAIL rand_budget: got %0d accepted want 200", accepted); end
    drain(ok);
    n_vec++; if (!ok) begin n_fail++; $display("FAIL rand_drain: got timeout want drained"); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 0; i < obsr_q.size() && i < expr_q.size(); i++) begin
      n_vec++; if (obsr_q[i] !== expr_q[i]) begin n_fail++; $display("FAIL rand_relu_word%0d: got %h want %h", i, obsr_q[i], expr_q[i]); end
    end
    n_vec++; if (clamp_cnt !== 16'(cnt_m)) begin n_fail++; $display("FAIL rand_cnt: got %0d want %0d", clamp_cnt, cnt_m); end
    n_vec++; if (clamp_cnt_r !== 16'(cnt_mr)) begin n_fail++; $display("FAIL rand_relu_cnt: got %0d want %0d", clamp_cnt_r, cnt_mr); end
    clear_q();
  endtask

  task automatic test_reset_mid;
    in_valid = 1'b1; in_mode = 1'b0; in_int = 28'(-1000); in_shift = 5'd2;
    out_ready = 1'b1; clr = 1'b0;
    repeat (4) @(posedge clk); #1;
    n_vec++; if (clamp_cnt !== 16'(cnt_m) || cnt_m == 0) begin n_fail++; $display("FAIL rstmid_pre_cnt: got %0d want %0d (nonzero)", clamp_cnt, cnt_m); end
    #2; rst = 1'b1; #1;
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL rstmid_data: got %h want 0000", out_data); end
    n_vec++; if (clamp_cnt !== 16'h0) begin n_fail++; $display("FAIL rstmid_cnt: got %h want 0000", clamp_cnt); end
    n_vec++; if (out_valid_r !== 1'b0) begin n_fail++; $display("FAIL rstmid_relu_valid: got %b want 0", out_valid_r); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_flushed%0d: got %b want 0", i, out_valid); end
    end
    clear_q();
  endtask

  task automatic test_counter_sat;
    bit ok;
    clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    in_valid = 1'b1; in_mode = 1'b0; in_int = 28'(-1000); in_shift = 5'd2;
    repeat (65540) @(posedge clk);
    #1;
    n_vec++; if (clamp_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt: got %h want ffff", clamp_cnt); end
    n_vec++; if (clamp_cnt_r !== 16'hFFFF) begin n_fail++; $display("FAIL sat_relu_cnt: got %h want ffff", clamp_cnt_r); end
    n_vec++; if ({out_valid, out_clamp} !== 2'b11) begin n_fail++; $display("FAIL clr_precond: got %b want 11", {out_valid, out_clamp}); end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    n_vec++; if (clamp_cnt !== 16'h0) begin n_fail++; $display("FAIL clr_wins: got %h want 0000", clamp_cnt); end
    @(posedge clk); #1;
    n_vec++; if (clamp_cnt !== 16'h1) begin n_fail++; $display("FAIL clr_then_inc: got %h want 0001", clamp_cnt); end
    drain(ok);
    n_vec++; if (!ok) begin n_fail++; $display("FAIL sat_drain: got timeout want drained"); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL sat_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    clear_q();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_counter_sat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
